// File: rtl/mmio_node_capture_pkg.sv
// Shared constants and types for the NODE_POINT / CPU_DONE snoop stage.
//   NodeAddr / DoneAddr : memory-mapped store addresses watched on the CPU write bus
//   Depth / NodeW       : default capture FIFO depth and stored node-index width
//   state_e             : capture FSM encoding (Idle=0, Capture=1, Done=2)
package mmio_node_capture_pkg;

   localparam logic [31:0] NodeAddr = 32'h0200_0008;
   localparam logic [31:0] DoneAddr = 32'h0200_000C;
   localparam int unsigned Depth    = 16;
   localparam int unsigned NodeW    = 5;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCapture = 2'd1,
      StDone    = 2'd2
   } state_e;

endpackage

// File: rtl/mmio_node_capture_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   flush_i              : empty the FIFO (wins over push/pop)
//   push_i, data_i       : write request and data; ignored when full without a pop
//   pop_i                : consume head; ignored when empty
//   data_o               : head entry (0 when empty)
//   full_o, empty_o      : occupancy flags
//   count_o              : occupied entries, 0..Depth
module mmio_node_capture_fifo #(
   parameter int unsigned Depth = 16,  // power of 2, >= 2
   parameter int unsigned Width = 5,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned CntW = $clog2(Depth) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

   assign pop_ok  = pop_i & ~empty_o & ~flush_i;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_ok) wr_d = wr_q + PtrW'(1);
         if (pop_ok)  rd_d = rd_q + PtrW'(1);
         if (push_ok && !pop_ok) cnt_d = cnt_q + CntW'(1);
         if (pop_ok && !push_ok) cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the head is masked to 0 whenever the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

   assign data_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/mmio_node_capture.sv
// Snoops the CPU data-memory write bus: queues NODE_POINT stores in a FIFO and
// flags the CPU_DONE store. Passive; never stalls the CPU.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   cpu_reset_i          : CPU held in reset; forces Idle and clears capture state
//   clear_i              : sync pulse; flush FIFO, clear flags, return to Idle
//   mem_write_i, data_adr_i, write_data_i : CPU store bus
//   out_valid_o/out_ready_i/out_node_o    : head-of-FIFO handshake
//   count_o              : FIFO occupancy
//   done_o               : CPU_DONE seen
//   overflow_o           : sticky, a capture was dropped on a full FIFO
//   range_err_o          : sticky, a captured value had bits above NodeW set
module mmio_node_capture
   import mmio_node_capture_pkg::*;
#(
   parameter int unsigned Depth_p = Depth,
   parameter int unsigned NodeW_p = NodeW,
   localparam int unsigned CntW   = $clog2(Depth_p) + 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               cpu_reset_i,
   input  logic               clear_i,
   input  logic               mem_write_i,
   input  logic [31:0]        data_adr_i,
   input  logic [31:0]        write_data_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [NodeW_p-1:0] out_node_o,
   output logic [CntW-1:0]    count_o,
   output logic               done_o,
   output logic               overflow_o,
   output logic               range_err_o
);

   state_e state_q, state_d;
   logic   overflow_q, overflow_d;
   logic   range_err_q, range_err_d;
   logic   flush, capture, node_hit, done_hit, push, pop, full, empty, high_bits;

   // cpu_reset in Idle is harmless to flush: the FIFO and flags are already clear.
   assign flush     = clear_i | cpu_reset_i;
   assign capture   = (state_q == StCapture) & mem_write_i;
   assign node_hit  = capture & (data_adr_i == NodeAddr);
   assign done_hit  = capture & (data_adr_i == DoneAddr) & (write_data_i == 32'd1);
   assign push      = node_hit & ~flush;
   assign pop       = out_valid_o & out_ready_i;
   assign high_bits = |write_data_i[31:NodeW_p];

   assign out_valid_o = ~empty;
   assign done_o      = (state_q == StDone);
   assign overflow_o  = overflow_q;
   assign range_err_o = range_err_q;

   always_comb begin
      state_d     = state_q;
      overflow_d  = overflow_q;
      range_err_d = range_err_q;
      if (clear_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:    if (!cpu_reset_i) state_d = StCapture;
            StCapture: begin
               if (cpu_reset_i)   state_d = StIdle;
               else if (done_hit) state_d = StDone;
            end
            StDone:    if (cpu_reset_i) state_d = StIdle;
            default:   state_d = StIdle;
         endcase
      end
      if (flush) begin
         overflow_d  = 1'b0;
         range_err_d = 1'b0;
      end else if (push) begin
         if (full && !pop) overflow_d = 1'b1;
         if (high_bits)    range_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         overflow_q  <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         overflow_q  <= overflow_d;
         range_err_q <= range_err_d;
      end
   end

   mmio_node_capture_fifo #(
      .Depth (Depth_p),
      .Width (NodeW_p)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (write_data_i[NodeW_p-1:0]),
      .data_o  (out_node_o),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count_o)
   );

endmodule

// File: tb/tb_mmio_node_capture.sv
module tb_mmio_node_capture;

   localparam logic [31:0] NODE = 32'h0200_0008;
   localparam logic [31:0] DONE = 32'h0200_000C;

   logic        clk = 1'b0;
   logic        rst_n, cpu_reset, clear, mem_write, out_ready;
   logic [31:0] data_adr, write_data;
   logic        out_valid, done, overflow, range_err;
   logic [4:0]  out_node;
   logic [4:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mmio_node_capture dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cpu_reset_i  (cpu_reset),
      .clear_i      (clear),
      .mem_write_i  (mem_write),
      .data_adr_i   (data_adr),
      .write_data_i (write_data),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_node_o   (out_node),
      .count_o      (count),
      .done_o       (done),
      .overflow_o   (overflow),
      .range_err_o  (range_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input logic [31:0] adr, input logic [31:0] dat);
      mem_write  = 1'b1;
      data_adr   = adr;
      write_data = dat;
   endtask

   task automatic idle();
      mem_write = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; cpu_reset = 1'b1; clear = 1'b0; mem_write = 1'b0;
      out_ready = 1'b0; data_adr = '0; write_data = '0;
      #3;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_count", 32'(count), 0);
      check("rst_node", 32'(out_node), 0);
      check("rst_flags", {29'd0, done, overflow, range_err}, 0);
      step();
      rst_n = 1'b1; cpu_reset = 1'b0;
      step();

      // 1: in-order capture with 1-cycle latency while draining
      out_ready = 1'b1;
      drive(NODE, 3);  step();
      check("t1_valid", 32'(out_valid), 1);
      check("t1_node3", 32'(out_node), 3);
      check("t1_count", 32'(count), 1);
      drive(NODE, 7);  step();
      check("t1_node7", 32'(out_node), 7);
      check("t1_count_pp", 32'(count), 1);
      drive(NODE, 12); step();
      check("t1_node12", 32'(out_node), 12);
      idle(); step();
      check("t1_empty_cnt", 32'(count), 0);
      check("t1_empty_vld", 32'(out_valid), 0);

      // 2: overflow on the 17th store, first 16 drain in order
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(NODE, 32'(i)); step();
      end
      idle();
      check("t2_count", 32'(count), 16);
      check("t2_overflow", 32'(overflow), 1);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t2_drain%0d", i), 32'(out_node), 32'(i));
         step();
      end
      check("t2_drained", 32'(count), 0);
      check("t2_ovf_sticky", 32'(overflow), 1);
      out_ready = 1'b0;
      pulse_clear();
      check("t2_clr_ovf", 32'(overflow), 0);
      // First cycle after clear is Idle: this store must be ignored
      drive(NODE, 5); step(); idle();
      check("t2_idle_ignore", 32'(count), 0);

      // 3: full FIFO with push+pop in the same cycle
      for (int i = 0; i < 16; i++) begin
         drive(NODE, 32'(i + 8)); step();
      end
      idle();
      check("t3_full", 32'(count), 16);
      out_ready = 1'b1;
      drive(NODE, 30);
      check("t3_head", 32'(out_node), 8);
      step(); idle();
      check("t3_count", 32'(count), 16);
      check("t3_no_ovf", 32'(overflow), 0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t3_drain%0d", i), 32'(out_node), (i < 15) ? 32'(i + 9) : 32'd30);
         step();
      end
      check("t3_drained", 32'(count), 0);
      out_ready = 1'b0;
      pulse_clear(); step();

      // 4: done only on value 1; later stores ignored; drain continues
      drive(NODE, 9); step(); idle();
      check("t4_count", 32'(count), 1);
      drive(DONE, 2); step();
      check("t4_done_2", 32'(done), 0);
      drive(DONE, 1); step();
      check("t4_done_1", 32'(done), 1);
      drive(NODE, 4); step(); idle();
      check("t4_ignored", 32'(count), 1);
      out_ready = 1'b1;
      check("t4_head", 32'(out_node), 9);
      check("t4_valid", 32'(out_valid), 1);
      step();
      check("t4_empty", 32'(out_valid), 0);
      check("t4_done_hold", 32'(done), 1);
      out_ready = 1'b0;
      pulse_clear();
      check("t4_done_clr", 32'(done), 0);
      step();

      // 5: out-of-range node value is truncated and flagged
      drive(NODE, 32'h25); step(); idle();
      check("t5_node", 32'(out_node), 5);
      check("t5_range", 32'(range_err), 1);
      check("t5_count", 32'(count), 1);

      // 6: async reset mid-capture, then cpu_reset blocks capture
      for (int i = 0; i < 3; i++) begin
         drive(NODE, 32'(i + 1)); step();
      end
      idle();
      check("t6_count4", 32'(count), 4);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_count", 32'(count), 0);
      check("t6_rst_valid", 32'(out_valid), 0);
      check("t6_rst_node", 32'(out_node), 0);
      check("t6_rst_flags", {29'd0, done, overflow, range_err}, 0);
      step();
      rst_n = 1'b1; cpu_reset = 1'b1;
      step();
      drive(NODE, 6); step(); idle();
      check("t6_cpurst_idle", 32'(count), 0);
      cpu_reset = 1'b0; step();
      cpu_reset = 1'b1; drive(NODE, 7); step(); idle();
      check("t6_cpurst_cap", 32'(count), 0);
      cpu_reset = 1'b0; step();
      drive(NODE, 8); step(); idle();
      check("t6_recover_cnt", 32'(count), 1);
      check("t6_recover_node", 32'(out_node), 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
